// File: rtl/pipe_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks post-decode producers, stalls load-use, selects forwarding.
// Optional saturating stall counter output enabled by defining PIPE_SCOREBOARD_STALL_CNT_EN.
module pipe_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  localparam int FW        = ($clog2(STAGES) > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic              use_a,
  input  logic              use_b,
  input  logic [REG_AW-1:0] dst,
  input  logic              dst_wr,
  input  logic              dst_load,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              ex_valid,
  output logic              busy
`ifdef PIPE_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_wr;
  logic [STAGES-1:0] r_load;
  logic [REG_AW-1:0] r_dst [STAGES];
  logic [FW-1:0]     r_fwd_a;
  logic [FW-1:0]     r_fwd_b;

  logic              w_haz_a;
  logic              w_haz_b;
  logic [FW-1:0]     w_fwd_a;
  logic [FW-1:0]     w_fwd_b;
  logic              w_stall;
  logic              w_issue_fire;

  // Scan oldest to youngest so the youngest matching producer overwrites older ones.
  // A producer in the last stage retires this edge and the register file supplies it.
  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (use_a && (src_a != '0) && r_valid[k] && r_wr[k] && (r_dst[k] == src_a)) begin
        w_haz_a = r_load[k] && ((k + 1) < LOAD_STAGE);
        w_fwd_a = ((k + 1) <= (STAGES - 1)) ? FW'(k + 1) : '0;
      end
      if (use_b && (src_b != '0) && r_valid[k] && r_wr[k] && (r_dst[k] == src_b)) begin
        w_haz_b = r_load[k] && ((k + 1) < LOAD_STAGE);
        w_fwd_b = ((k + 1) <= (STAGES - 1)) ? FW'(k + 1) : '0;
      end
    end
  end

  assign w_stall      = issue_valid & ~flush & (w_haz_a | w_haz_b);
  assign w_issue_fire = issue_valid & ~w_stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_load  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_dst[k] <= '0;
      end
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_load[k]  <= r_load[k-1];
        r_dst[k]   <= r_dst[k-1];
      end
      r_valid[0] <= w_issue_fire;
      r_wr[0]    <= w_issue_fire & dst_wr;
      r_load[0]  <= w_issue_fire & dst_load;
      r_dst[0]   <= w_issue_fire ? dst : '0;
      r_fwd_a    <= w_issue_fire ? w_fwd_a : '0;
      r_fwd_b    <= w_issue_fire ? w_fwd_b : '0;
    end
  end

`ifdef PIPE_SCOREBOARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign stall      = w_stall;
  assign issue_fire = w_issue_fire;
  assign fwd_a      = r_fwd_a;
  assign fwd_b      = r_fwd_b;
  assign ex_valid   = r_valid[0];
  assign busy       = |r_valid;

endmodule
